// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states
// and the datapath mux select values.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_AUIPC    = 4'd9,
    S_JALRADR  = 4'd10,
    S_JAL      = 4'd11,
    S_ALUWB    = 4'd12,
    S_BRANCH   = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Resolves the six RV32I branch conditions from the ALU compare flags.
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       valid_funct3
);

  always_comb begin
    taken        = 1'b0;
    valid_funct3 = 1'b1;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: valid_funct3 = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects and write enables.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit          MEM_WAIT        = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned IMM_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [IMM_W-1:0] imm_src,
  output logic             instr_done,
  output logic             illegal
);

  state_e state_q, state_d;
  logic   rdy;
  logic   br_taken;
  logic   br_valid;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  branch_cond u_branch_cond (
    .funct3       (funct3),
    .zero         (zero),
    .lt           (lt),
    .ltu          (ltu),
    .taken        (br_taken),
    .valid_funct3 (br_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = br_valid ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_JALRADR:  state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is high the outputs look like FETCH with every strobe held off.
  always_comb begin
    state_e cur;
    cur        = reset ? S_FETCH : state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    imm_src    = IMM_W'(imm_src_of(op));
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = rdy;
        pc_write   = rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_JALRADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = rdy;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_SUB;
        instr_done = 1'b1;
        pc_write   = br_taken;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
